// File: rtl/register_file.sv
// Architectural register file with per-register rename tags, zero-latency operand queries.
// Optional same-cycle commit bypass on queries: define RF_COMMIT_BYPASS_EN.
module register_file #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int ROB_ID_WIDTH   = 5,
  parameter int XLEN           = 32
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      rdy_in,
  input  logic                      _clear,
  input  logic                      _launch_ready,
  input  logic [ROB_ID_WIDTH-1:0]   _launch_rob_id,
  input  logic [REG_ADDR_WIDTH-1:0] _launch_register_id,
  input  logic                      _commit_ready,
  input  logic [ROB_ID_WIDTH-1:0]   _commit_rob_id,
  input  logic [REG_ADDR_WIDTH-1:0] _commit_register_id,
  input  logic [XLEN-1:0]           _commit_value,
  input  logic [REG_ADDR_WIDTH-1:0] _get_register_status_1,
  input  logic [REG_ADDR_WIDTH-1:0] _get_register_status_2,
  output logic                      _register_dep_valid_1,
  output logic [ROB_ID_WIDTH-1:0]   _register_dep_1,
  output logic [XLEN-1:0]           _register_value_1,
  output logic                      _register_dep_valid_2,
  output logic [ROB_ID_WIDTH-1:0]   _register_dep_2,
  output logic [XLEN-1:0]           _register_value_2
);

  localparam int NUM_REGS = 2 ** REG_ADDR_WIDTH;

  typedef struct packed {
    logic                    dep_valid;
    logic [ROB_ID_WIDTH-1:0] dep;
    logic [XLEN-1:0]         value;
  } query_t;

  logic [XLEN-1:0]         value_q [NUM_REGS];
  logic [ROB_ID_WIDTH-1:0] tag_q   [NUM_REGS];
  logic [NUM_REGS-1:0]     busy_q;

  logic commit_hit;
  logic launch_hit;

  assign commit_hit = _commit_ready && (_commit_register_id != '0);
  assign launch_hit = _launch_ready && (_launch_register_id != '0);

  // Launch is written after commit so that a same-cycle launch to the same rd wins busy/tag.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy_q <= '0;
      for (int r = 0; r < NUM_REGS; r++) begin
        value_q[r] <= '0;
        tag_q[r]   <= '0;
      end
    end else if (rdy_in) begin
      if (commit_hit) begin
        value_q[_commit_register_id] <= _commit_value;
        if (tag_q[_commit_register_id] == _commit_rob_id)
          busy_q[_commit_register_id] <= 1'b0;
      end
      if (_clear) begin
        busy_q <= '0;
      end else if (launch_hit) begin
        busy_q[_launch_register_id] <= 1'b1;
        tag_q[_launch_register_id]  <= _launch_rob_id;
      end
    end
  end

  function automatic query_t lookup(input logic [REG_ADDR_WIDTH-1:0] idx);
    query_t q;
    q = '0;
    if (idx != '0) begin
      if (busy_q[idx]) begin
        q.dep_valid = 1'b1;
        q.dep       = tag_q[idx];
`ifdef RF_COMMIT_BYPASS_EN
        // Producer is retiring right now; hand its value over instead of a stale ROB id.
        if (_commit_ready && (idx == _commit_register_id) && (tag_q[idx] == _commit_rob_id)) begin
          q.dep_valid = 1'b0;
          q.dep       = '0;
          q.value     = _commit_value;
        end
`endif
      end else begin
        q.value = value_q[idx];
      end
    end
    return q;
  endfunction

  query_t query_1;
  query_t query_2;

  always_comb begin
    query_1 = lookup(_get_register_status_1);
    query_2 = lookup(_get_register_status_2);
  end

  assign _register_dep_valid_1 = query_1.dep_valid;
  assign _register_dep_1       = query_1.dep;
  assign _register_value_1     = query_1.value;
  assign _register_dep_valid_2 = query_2.dep_valid;
  assign _register_dep_2       = query_2.dep;
  assign _register_value_2     = query_2.value;

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file: rename, commit, flush, x0 and stall cases.
module tb_register_file;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        _clear;
  logic        _launch_ready;
  logic [4:0]  _launch_rob_id;
  logic [4:0]  _launch_register_id;
  logic        _commit_ready;
  logic [4:0]  _commit_rob_id;
  logic [4:0]  _commit_register_id;
  logic [31:0] _commit_value;
  logic [4:0]  _get_register_status_1;
  logic [4:0]  _get_register_status_2;
  logic        _register_dep_valid_1;
  logic [4:0]  _register_dep_1;
  logic [31:0] _register_value_1;
  logic        _register_dep_valid_2;
  logic [4:0]  _register_dep_2;
  logic [31:0] _register_value_2;

  int n_checks = 0;
  int n_fail   = 0;

  register_file dut (
    .clk_in                (clk_in),
    .rst_in                (rst_in),
    .rdy_in                (rdy_in),
    ._clear                (_clear),
    ._launch_ready         (_launch_ready),
    ._launch_rob_id        (_launch_rob_id),
    ._launch_register_id   (_launch_register_id),
    ._commit_ready         (_commit_ready),
    ._commit_rob_id        (_commit_rob_id),
    ._commit_register_id   (_commit_register_id),
    ._commit_value         (_commit_value),
    ._get_register_status_1(_get_register_status_1),
    ._get_register_status_2(_get_register_status_2),
    ._register_dep_valid_1 (_register_dep_valid_1),
    ._register_dep_1       (_register_dep_1),
    ._register_value_1     (_register_value_1),
    ._register_dep_valid_2 (_register_dep_valid_2),
    ._register_dep_2       (_register_dep_2),
    ._register_value_2     (_register_value_2)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Checks query port 1: dep_valid, dep, value.
  task automatic check_q1(input string tag, input logic dv, input logic [4:0] dep, input logic [31:0] val);
    check({tag, ".dv1"},  32'(_register_dep_valid_1), 32'(dv));
    check({tag, ".dep1"}, 32'(_register_dep_1),       32'(dep));
    check({tag, ".val1"}, _register_value_1,          val);
  endtask

  task automatic check_q2(input string tag, input logic dv, input logic [4:0] dep, input logic [31:0] val);
    check({tag, ".dv2"},  32'(_register_dep_valid_2), 32'(dv));
    check({tag, ".dep2"}, 32'(_register_dep_2),       32'(dep));
    check({tag, ".val2"}, _register_value_2,          val);
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    _clear        = 1'b0;
    _launch_ready = 1'b0;
    _commit_ready = 1'b0;
  endtask

  task automatic launch(input logic [4:0] rd, input logic [4:0] rob);
    _launch_ready       = 1'b1;
    _launch_register_id = rd;
    _launch_rob_id      = rob;
  endtask

  task automatic commit(input logic [4:0] rd, input logic [4:0] rob, input logic [31:0] val);
    _commit_ready       = 1'b1;
    _commit_register_id = rd;
    _commit_rob_id      = rob;
    _commit_value       = val;
  endtask

  initial begin
    rst_in = 1'b1;
    rdy_in = 1'b1;
    idle();
    _launch_rob_id = '0; _launch_register_id = '0;
    _commit_rob_id = '0; _commit_register_id = '0; _commit_value = '0;
    _get_register_status_1 = 5'd5;
    _get_register_status_2 = 5'd6;
    step();
    step();
    rst_in = 1'b0;

    // 1: reset state
    check_q1("rst_x5", 1'b0, 5'd0, 32'h0);
    check_q2("rst_x6", 1'b0, 5'd0, 32'h0);

    // 2: launch then commit x5
    launch(5'd5, 5'd3);
    step(); idle();
    check_q1("t2_busy", 1'b1, 5'd3, 32'h0);
    commit(5'd5, 5'd3, 32'hDEADBEEF);
    #1;
`ifdef RF_COMMIT_BYPASS_EN
    check_q1("t2_bypass", 1'b0, 5'd0, 32'hDEADBEEF);
`else
    check_q1("t2_nobypass", 1'b1, 5'd3, 32'h0);
`endif
    step(); idle();
    check_q1("t2_done", 1'b0, 5'd0, 32'hDEADBEEF);

    // 3: youngest producer wins
    _get_register_status_2 = 5'd7;
    launch(5'd7, 5'd1); step();
    launch(5'd7, 5'd4); step(); idle();
    commit(5'd7, 5'd1, 32'h11); step(); idle();
    check_q2("t3_stale_commit", 1'b1, 5'd4, 32'h0);
    commit(5'd7, 5'd4, 32'h22); step(); idle();
    check_q2("t3_final", 1'b0, 5'd0, 32'h22);

    // 4: same-cycle commit + launch on x9; then different-rd pair
    _get_register_status_1 = 5'd9;
    _get_register_status_2 = 5'd10;
    launch(5'd9, 5'd2); step(); idle();
    commit(5'd9, 5'd2, 32'h55);
    launch(5'd9, 5'd6);
    step(); idle();
    check_q1("t4_launch_wins", 1'b1, 5'd6, 32'h0);
    commit(5'd9, 5'd6, 32'h77);
    launch(5'd10, 5'd3);
    step(); idle();
    check_q1("t4_new_value", 1'b0, 5'd0, 32'h77);
    check_q2("t4_indep_launch", 1'b1, 5'd3, 32'h0);

    // 5: flush with concurrent commit; launch in flush cycle dropped
    commit(5'd2, 5'd0, 32'hA2); step(); idle();
    commit(5'd3, 5'd0, 32'hA3); step(); idle();
    launch(5'd1, 5'd1); step();
    launch(5'd2, 5'd2); step();
    launch(5'd3, 5'd3); step(); idle();
    _get_register_status_1 = 5'd2;
    _get_register_status_2 = 5'd3;
    #1;
    check_q1("t5_x2_busy", 1'b1, 5'd2, 32'h0);
    _clear = 1'b1;
    commit(5'd1, 5'd1, 32'h99);
    launch(5'd4, 5'd7);
    step(); idle();
    check_q1("t5_x2_flushed", 1'b0, 5'd0, 32'hA2);
    check_q2("t5_x3_flushed", 1'b0, 5'd0, 32'hA3);
    _get_register_status_1 = 5'd1;
    _get_register_status_2 = 5'd4;
    #1;
    check_q1("t5_x1_committed", 1'b0, 5'd0, 32'h99);
    check_q2("t5_x4_dropped", 1'b0, 5'd0, 32'h0);

    // 6: x0 writes ignored; rdy_in=0 freezes state
    _get_register_status_1 = 5'd0;
    launch(5'd0, 5'd5);
    commit(5'd0, 5'd5, 32'h1234);
    step(); idle();
    check_q1("t6_x0", 1'b0, 5'd0, 32'h0);
    _get_register_status_1 = 5'd5;
    rdy_in = 1'b0;
    launch(5'd4, 5'd8);
    step();
    commit(5'd5, 5'd0, 32'hBAD0BAD0);
    step(); idle();
    rdy_in = 1'b1;
    #1;
    check_q2("t6_stall_launch", 1'b0, 5'd0, 32'h0);
    check_q1("t6_stall_commit", 1'b0, 5'd0, 32'hDEADBEEF);

    // reset overrides rdy_in=0
    rdy_in = 1'b0;
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    rdy_in = 1'b1;
    #1;
    check_q1("rst2_x5", 1'b0, 5'd0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
